// File: rtl/uart_pkg.sv
// Shared definitions for the N-byte UART link: FSM encodings, inter-character
// timeout and the mid-bit sample point.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP,
    TX_DONE
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Bit periods of idle line after a character before a partial packet is dropped.
  localparam int unsigned TIMEOUT_BITS = 4;

  function automatic int unsigned mid_bit_count(input int unsigned clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with synchronous reload; flags the last
// cycle of each bit period and the mid-bit sample point.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned LOAD_VAL     = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic bit_end_o,
  output logic mid_o
);

  localparam int unsigned   CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID   = CW'(mid_bit_count(CLKS_PER_BIT));
  localparam logic [CW-1:0] LOADV = CW'(LOAD_VAL);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d is assigned on every path, so no latch is inferred.
  always_comb begin
    if (load_i)              cnt_d = LOADV;
    else if (cnt_q == LAST)  cnt_d = '0;
    else                     cnt_d = cnt_q + CW'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bit_end_o = (cnt_q == LAST);
  assign mid_o     = (cnt_q == MID);

endmodule

// File: rtl/uart_nbyte_link.sv
// Packet UART: sends/receives NBYTES characters back-to-back, with optional
// internal loopback. Define UART_PARITY_EN to add a parity bit per character.
module uart_nbyte_link
  import uart_pkg::*;
#(
  parameter int unsigned NBYTES       = 8,
  parameter int unsigned DBITS        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tx_start,
  input  logic [NBYTES*DBITS-1:0] tx_data,
  output logic                    tx_busy,
  output logic                    tx_done,
  output logic                    txd,
  input  logic                    rxd,
  input  logic                    loopback_en,
  output logic [NBYTES*DBITS-1:0] rx_data,
  output logic                    rx_valid,
  output logic                    rx_frame_err,
  output logic                    rx_parity_err
);

  localparam int unsigned   PW        = NBYTES * DBITS;
  localparam int unsigned   BW        = $clog2(DBITS);
  localparam int unsigned   NW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned   TW        = $clog2(TIMEOUT_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DBITS - 1);
  localparam logic [NW-1:0] LAST_BYTE = NW'(NBYTES - 1);

  // ---------------- transmitter ----------------
  tx_state_e     tx_state_q;
  logic [PW-1:0] tx_sh_q;
  logic [BW-1:0] tx_bit_q;
  logic [NW-1:0] tx_byte_q;
  logic          txd_q, tx_busy_q, tx_done_q;
  logic          tx_load, tx_bit_end, tx_mid_unused;
`ifdef UART_PARITY_EN
  logic          tx_par_q;
`else
  localparam bit unused_parity_odd = PARITY_ODD;
`endif

  assign tx_load = (tx_state_q == TX_IDLE) || (tx_state_q == TX_DONE);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .LOAD_VAL(0)) u_tx_timer (
    .clk(clk), .rst_n(reset), .load_i(tx_load),
    .bit_end_o(tx_bit_end), .mid_o(tx_mid_unused)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE, TX_DONE: begin
          tx_state_q <= TX_IDLE;
          if (tx_start) begin
            tx_state_q <= TX_START;
            tx_sh_q    <= tx_data;
            tx_byte_q  <= '0;
            txd_q      <= 1'b0;
            tx_busy_q  <= 1'b1;
          end
        end
        TX_START: if (tx_bit_end) begin
          tx_state_q <= TX_DATA;
          tx_bit_q   <= '0;
          txd_q      <= tx_sh_q[0];
`ifdef UART_PARITY_EN
          tx_par_q   <= (^tx_sh_q[DBITS-1:0]) ^ PARITY_ODD;
`endif
        end
        TX_DATA: if (tx_bit_end) begin
          tx_sh_q <= tx_sh_q >> 1;
          if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_state_q <= TX_PARITY;
            txd_q      <= tx_par_q;
`else
            tx_state_q <= TX_STOP;
            txd_q      <= 1'b1;
`endif
          end else begin
            tx_bit_q <= tx_bit_q + BW'(1);
            txd_q    <= tx_sh_q[1];
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: if (tx_bit_end) begin
          tx_state_q <= TX_STOP;
          txd_q      <= 1'b1;
        end
`endif
        TX_STOP: if (tx_bit_end) begin
          if (tx_byte_q == LAST_BYTE) begin
            tx_state_q <= TX_DONE;
            tx_done_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
          end else begin
            tx_state_q <= TX_START;
            tx_byte_q  <= tx_byte_q + NW'(1);
            txd_q      <= 1'b0;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign txd     = txd_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

  // ---------------- receiver ----------------
  rx_state_e     rx_state_q;
  logic          sync1_q, sync2_q, line_prev_q;
  logic [PW-1:0] rx_sh_q, rx_data_q;
  logic [BW-1:0] rx_bit_q;
  logic [NW-1:0] rx_byte_q;
  logic [TW-1:0] rx_idle_q;
  logic          rx_ferr_acc_q, rx_valid_q, rx_frame_err_q;
  logic          rx_fall, rx_load, rx_bit_end, rx_mid;
`ifdef UART_PARITY_EN
  logic          rx_perr_acc_q, rx_parity_err_q;
`endif

  // Synchroniser idles high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
    end else begin
      sync1_q     <= loopback_en ? txd_q : rxd;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
    end
  end

  assign rx_fall = line_prev_q & ~sync2_q;
  // Reload to 1 so the count equals the position within the start bit.
  assign rx_load = (rx_state_q == RX_IDLE) && rx_fall;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .LOAD_VAL(1)) u_rx_timer (
    .clk(clk), .rst_n(reset), .load_i(rx_load),
    .bit_end_o(rx_bit_end), .mid_o(rx_mid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q      <= RX_IDLE;
      rx_sh_q         <= '0;
      rx_data_q       <= '0;
      rx_bit_q        <= '0;
      rx_byte_q       <= '0;
      rx_idle_q       <= '0;
      rx_ferr_acc_q   <= 1'b0;
      rx_valid_q      <= 1'b0;
      rx_frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_acc_q   <= 1'b0;
      rx_parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      rx_parity_err_q <= 1'b0;
`endif
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state_q <= RX_START;
          end else if (rx_bit_end && (rx_byte_q != '0)) begin
            if (rx_idle_q == TW'(TIMEOUT_BITS)) begin
              rx_byte_q     <= '0;
              rx_ferr_acc_q <= 1'b0;
`ifdef UART_PARITY_EN
              rx_perr_acc_q <= 1'b0;
`endif
            end else begin
              rx_idle_q <= rx_idle_q + TW'(1);
            end
          end
        end
        RX_START: if (rx_mid) begin
          rx_state_q <= sync2_q ? RX_IDLE : RX_DATA;
          rx_bit_q   <= '0;
        end
        RX_DATA: if (rx_mid) begin
          rx_sh_q <= {sync2_q, rx_sh_q[PW-1:1]};
          if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_state_q <= RX_PARITY;
`else
            rx_state_q <= RX_STOP;
`endif
          end else begin
            rx_bit_q <= rx_bit_q + BW'(1);
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: if (rx_mid) begin
          rx_state_q <= RX_STOP;
          if (sync2_q != ((^rx_sh_q[PW-1 -: DBITS]) ^ PARITY_ODD)) rx_perr_acc_q <= 1'b1;
        end
`endif
        RX_STOP: if (rx_mid) begin
          rx_state_q <= RX_IDLE;
          rx_idle_q  <= '0;
          if (rx_byte_q == LAST_BYTE) begin
            rx_data_q       <= rx_sh_q;
            rx_valid_q      <= 1'b1;
            rx_frame_err_q  <= rx_ferr_acc_q | ~sync2_q;
            rx_byte_q       <= '0;
            rx_ferr_acc_q   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err_q <= rx_perr_acc_q;
            rx_perr_acc_q   <= 1'b0;
`endif
          end else begin
            rx_byte_q     <= rx_byte_q + NW'(1);
            rx_ferr_acc_q <= rx_ferr_acc_q | ~sync2_q;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = rx_parity_err_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_nbyte_link.sv
// Directed bench for uart_nbyte_link (NBYTES=2, DBITS=8, CLKS_PER_BIT=4):
// table of packets over loopback and external rxd, then multi-cycle corner cases.
module tb_uart_nbyte_link;

  localparam int unsigned CPB  = 4;
  localparam bit          PODD = 1'b0;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int TX_DONE_LAT = PAR_EN ? 89 : 81;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tx_start = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_busy, tx_done, txd;
  logic        rxd = 1'b1;
  logic        loopback_en = 1'b0;
  logic [15:0] rx_data;
  logic        rx_valid, rx_frame_err, rx_parity_err;

  uart_nbyte_link #(.NBYTES(2), .DBITS(8), .CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .txd(txd), .rxd(rxd),
    .loopback_en(loopback_en), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          valid_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] cap_data = '0;
  logic        cap_ferr = 1'b0;
  logic        cap_perr = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      cap_data = rx_data;
      cap_ferr = rx_frame_err;
      cap_perr = rx_parity_err;
    end
    if (tx_done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] b, input logic stop_v, input logic par_flip);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    if (PAR_EN) begin
      rxd = (^b) ^ PODD ^ par_flip;
      tick(CPB);
    end
    rxd = stop_v;
    tick(CPB);
    rxd = 1'b1;
  endtask

  task automatic wait_valid(input int base, input int budget, output bit got);
    int n = 0;
    while (valid_cnt == base && n < budget) begin
      tick();
      n++;
    end
    got = (valid_cnt != base);
  endtask

  task automatic wait_done(input int start_n, input int budget, output int n);
    n = start_n;
    while (tx_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    bit          loop;
    logic [15:0] data;
    logic [1:0]  stop_v;
    logic [1:0]  par_flip;
    logic [15:0] exp_data;
    logic        exp_ferr;
    logic        exp_perr;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  initial begin
    bit got;
    int n, base, dbase;

    vecs[0] = '{loop: 1'b1, data: 16'hA55A, stop_v: 2'b11, par_flip: 2'b00, exp_data: 16'hA55A, exp_ferr: 1'b0, exp_perr: 1'b0};
    vecs[1] = '{loop: 1'b0, data: 16'hC33C, stop_v: 2'b01, par_flip: 2'b00, exp_data: 16'hC33C, exp_ferr: 1'b1, exp_perr: 1'b0};
    vecs[2] = '{loop: 1'b0, data: 16'h0000, stop_v: 2'b11, par_flip: 2'b00, exp_data: 16'h0000, exp_ferr: 1'b0, exp_perr: 1'b0};
    vecs[3] = '{loop: 1'b0, data: 16'hFFFF, stop_v: 2'b11, par_flip: 2'b00, exp_data: 16'hFFFF, exp_ferr: 1'b0, exp_perr: 1'b0};
    vecs[4] = '{loop: 1'b1, data: 16'h1234, stop_v: 2'b11, par_flip: 2'b00, exp_data: 16'h1234, exp_ferr: 1'b0, exp_perr: 1'b0};
    vecs[5] = '{loop: 1'b0, data: 16'h0201, stop_v: 2'b11, par_flip: 2'b01, exp_data: 16'h0201, exp_ferr: 1'b0, exp_perr: PAR_EN};

    // Reset state
    tick(3);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_frame_err", 32'(rx_frame_err), 32'd0);
    check("rst_parity_err", 32'(rx_parity_err), 32'd0);
    reset = 1'b1;
    tick(5);

    for (int v = 0; v < NV; v++) begin
      base = valid_cnt;
      if (vecs[v].loop) begin
        loopback_en = 1'b1;
        tx_data = vecs[v].data;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check("tx_txd_low_next", 32'(txd), 32'd0);
        check("tx_busy_rise", 32'(tx_busy), 32'd1);
        wait_done(1, 300, n);
        check("tx_done_latency", 32'(n), 32'(TX_DONE_LAT));
        check("tx_busy_at_done", 32'(tx_busy), 32'd0);
      end else begin
        loopback_en = 1'b0;
        send_char(vecs[v].data[7:0], vecs[v].stop_v[0], vecs[v].par_flip[0]);
        send_char(vecs[v].data[15:8], vecs[v].stop_v[1], vecs[v].par_flip[1]);
      end
      wait_valid(base, 100, got);
      check("vec_rx_valid", 32'(got), 32'd1);
      check("vec_rx_data", 32'(cap_data), 32'(vecs[v].exp_data));
      check("vec_frame_err", 32'(cap_ferr), 32'(vecs[v].exp_ferr));
      check("vec_parity_err", 32'(cap_perr), 32'(vecs[v].exp_perr));
      tick(12);
      check("vec_single_valid", 32'(valid_cnt), 32'(base + 1));
    end

    // False start: one-cycle glitch, then a good packet
    loopback_en = 1'b0;
    base = valid_cnt;
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    tick(10 * CPB);
    check("glitch_no_valid", 32'(valid_cnt), 32'(base));
    send_char(8'h96, 1'b1, 1'b0);
    send_char(8'h69, 1'b1, 1'b0);
    wait_valid(base, 100, got);
    check("glitch_then_valid", 32'(got), 32'd1);
    check("glitch_then_data", 32'(cap_data), 32'h6996);
    tick(12);

    // Inter-character timeout drops a lone byte
    base = valid_cnt;
    send_char(8'h77, 1'b1, 1'b0);
    tick(5 * CPB);
    check("timeout_no_valid", 32'(valid_cnt), 32'(base));
    send_char(8'hE1, 1'b1, 1'b0);
    send_char(8'h1E, 1'b1, 1'b0);
    wait_valid(base, 100, got);
    check("timeout_then_valid", 32'(got), 32'd1);
    check("timeout_then_data", 32'(cap_data), 32'h1EE1);
    tick(12);
    check("timeout_single_valid", 32'(valid_cnt), 32'(base + 1));

    // tx_start while busy is ignored
    loopback_en = 1'b1;
    base = valid_cnt;
    dbase = done_cnt;
    tx_data = 16'h3CC3;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tick(20);
    tx_data = 16'hFFFF;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    wait_done(22, 300, n);
    check("busy_done_latency", 32'(n), 32'(TX_DONE_LAT));
    wait_valid(base, 100, got);
    check("busy_rx_valid", 32'(got), 32'd1);
    check("busy_rx_data", 32'(cap_data), 32'h3CC3);
    tick(150);
    check("busy_one_packet", 32'(valid_cnt), 32'(base + 1));
    check("busy_one_done", 32'(done_cnt), 32'(dbase + 1));

    // Reset mid-transmission
    base = valid_cnt;
    dbase = done_cnt;
    tx_data = 16'h1234;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tick(30);
    reset = 1'b0;
    #1;
    check("rstmid_txd", 32'(txd), 32'd1);
    check("rstmid_busy", 32'(tx_busy), 32'd0);
    check("rstmid_rx_data", 32'(rx_data), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(150);
    check("rstmid_no_done", 32'(done_cnt), 32'(dbase));
    check("rstmid_no_valid", 32'(valid_cnt), 32'(base));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_nbyte_link.md
UART_NBYTE_LINK -- requirements
Module: uart_nbyte_link

Interface
REQ-001 SHALL have parameter NBYTES, default 8, bytes per packet (1..16).
REQ-002 SHALL have parameter DBITS, default 8, data bits per character (5..8).
REQ-003 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per bit period (>=4, even).
REQ-004 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port tx_start  input  1  single-cycle request to send tx_data.
REQ-007 SHALL have port tx_data  input  NBYTES*DBITS  packet; byte 0 = bits [DBITS-1:0].
REQ-008 SHALL have port tx_busy  output  1  high while a packet is being sent.
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse at packet end.
REQ-010 SHALL have port txd  output  1  serial line out, idle high.
REQ-011 SHALL have port rxd  input  1  serial line in, asynchronous.
REQ-012 SHALL have port loopback_en  input  1  when high, receiver uses txd in place of rxd.
REQ-013 SHALL have port rx_data  output  NBYTES*DBITS  last complete received packet.
REQ-014 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-015 SHALL have port rx_frame_err  output  1  one-cycle pulse with rx_valid if any stop bit in the packet sampled 0.
REQ-016 SHALL have port rx_parity_err  output  1  one-cycle pulse with rx_valid on any parity mismatch.

Function
REQ-017 SHALL frame each character as start(0), DBITS data LSB first, [parity], stop(1); each bit held exactly CLKS_PER_BIT cycles.
REQ-018 SHALL send bytes 0..NBYTES-1 back-to-back, no idle gap between characters.
REQ-019 SHALL capture tx_data on the tx_start cycle when tx_busy=0; txd goes low on the next cycle and tx_busy rises on that same cycle.
REQ-020 SHALL ignore tx_start while tx_busy=1; the in-flight packet is unaffected.
REQ-021 SHALL run TX FSM IDLE->START->DATA->[PARITY]->STOP->(START if bytes remain, else DONE)->IDLE; DONE lasts one cycle, drives tx_done=1, tx_busy=0.
REQ-022 SHALL pass rxd through a 2-flop synchroniser before use; the loopback mux precedes the synchroniser.
REQ-023 SHALL run RX FSM IDLE->START->DATA->[PARITY]->STOP; a falling line edge in IDLE enters START.
REQ-024 SHALL sample every bit at count CLKS_PER_BIT/2 of its period; a start bit sampled 1 is a false start and returns to IDLE with no side effects.
REQ-025 SHALL accumulate characters into an internal shift register with a byte counter; after the NBYTES-th stop sample, rx_data loads and rx_valid pulses on the next cycle.
REQ-026 SHALL accept a new start edge immediately after the stop-bit sample point.
REQ-027 SHALL discard a partial packet and clear the byte counter when no start edge arrives within 4 bit periods after a completed character; no rx_valid is produced.
REQ-028 SHALL still deliver the packet when stop or parity errors occur, flagged via REQ-015/016.
REQ-029 SHALL treat a loopback_en change as taking effect immediately; a resulting corrupt packet is permitted but the FSM never hangs.

Reset
REQ-030 SHALL, while reset=0, force txd=1, tx_busy=0, tx_done=0, rx_data=0, rx_valid=0, rx_frame_err=0, rx_parity_err=0, both FSMs IDLE, all counters 0, synchroniser flops 1.
REQ-031 SHALL abort any in-flight TX or RX packet on reset assertion mid-frame with no tx_done or rx_valid generated.

Configuration
REQ-032 SHALL, with UART_PARITY_EN defined, insert one parity bit after data (even by default; odd when parameter PARITY_ODD=1) and check it on receive.
REQ-033 SHALL, without UART_PARITY_EN, omit the PARITY states, ignore PARITY_ODD, and tie rx_parity_err to 0.

Structure
REQ-034 SHALL place FSM state encodings, the 4-bit-period inter-character timeout constant and the mid-bit sample formula in shared package uart_pkg.
REQ-035 SHALL implement bit timing in one sub-module uart_bit_timer (reloadable counter, bit-end and mid-bit strobes), instantiated once each for TX and RX.

Verification (NBYTES=2, DBITS=8, CLKS_PER_BIT=4 unless stated)
REQ-036 SHALL cover loopback: loopback_en=1, tx_start with tx_data=16'hA55A -> tx_done 81 cycles after tx_start; rx_valid with rx_data=16'hA55A, both error flags 0.
REQ-037 SHALL cover external rxd: drive bytes 8'h3C then 8'hC3 with a stop bit forced 0 on the second -> rx_data=16'hC33C, rx_valid=1 and rx_frame_err=1 together.
REQ-038 SHALL cover a false start: 1-cycle low glitch on rxd -> no rx_valid; a subsequent valid packet is received correctly.
REQ-039 SHALL cover timeout plus reset: send one byte then idle 5 bit periods -> no rx_valid; a later full packet is correct; reset asserted mid-TX -> txd=1 immediately, no tx_done.
REQ-040 SHALL cover parity with UART_PARITY_EN, PARITY_ODD=0: a corrupted parity bit on 8'h01 -> rx_parity_err=1 with rx_valid; a second tx_start during busy is ignored.
